// File: rtl/wb_fetch_pkg.sv
// Shared types and defaults for the wb_fetch_burst Wishbone burst-read master.
package wb_fetch_pkg;

   localparam int DEF_ADDR    = 12;
   localparam int DEF_WIDTH   = 32;
   localparam int DEF_LBITS   = 8;
   localparam int DEF_RETRY   = 3;
   localparam int DEF_TIMEOUT = 255;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_END
   } state_t;

   typedef enum logic [1:0] {
      AB_NONE,
      AB_ERR,
      AB_RETRY,
      AB_TIMEOUT
   } abort_t;

   // A retry is tolerated while fewer than `limit` have already been taken.
   function automatic logic retry_ok(input logic [15:0] tries, input int limit);
      return int'(tries) < limit;
   endfunction

endpackage

// File: rtl/wb_fetch_burst_watchdog.sv
// Bus-inactivity watchdog for wb_fetch_burst; only instantiated when
// WB_FETCH_TIMEOUT_EN is defined.
module wb_fetch_watchdog
   import wb_fetch_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
)(
   input  logic clk_i,
   input  logic rst_i,
   input  logic cyc,
   input  logic kick,
   output logic expire
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] cnt_q;

   assign expire = cyc && !kick && (cnt_q == TW'(TIMEOUT));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         cnt_q <= '0;
      else if (!cyc || kick)
         cnt_q <= '0;
      else if (cnt_q != TW'(TIMEOUT))
         cnt_q <= cnt_q + TW'(1);
   end

endmodule

// File: rtl/wb_fetch_burst.sv
// Wishbone B4 pipelined burst-read master with retry rewind and error abort.
// Optional build macro: WB_FETCH_TIMEOUT_EN adds a bus-inactivity watchdog.
module wb_fetch_burst
   import wb_fetch_pkg::*;
#(
   parameter int ADDR    = DEF_ADDR,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int LBITS   = DEF_LBITS,
   parameter int RETRY   = DEF_RETRY,
`ifdef WB_FETCH_TIMEOUT_EN
   parameter int TIMEOUT = DEF_TIMEOUT,
`endif
   parameter int DELAY   = 3
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             fetch_i,
   input  logic [ADDR-1:0]  base_i,
   input  logic [LBITS-1:0] len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             fail_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             cyc_o,
   output logic             stb_o,
   output logic             we_o,
   output logic [ADDR-1:0]  adr_o,
   input  logic             ack_i,
   input  logic             wat_i,
   input  logic             rty_i,
   input  logic             err_i,
   input  logic [WIDTH-1:0] dat_i
);

   localparam int CW = LBITS + 1;

   state_t           state_q, state_d;
   abort_t           cause;
   logic [ADDR-1:0]  base_q;
   logic [LBITS-1:0] len_q;
   logic [CW-1:0]    len_w;
   logic [CW-1:0]    sent_q, sent_d, rcvd_q, rcvd_d, tries_q, tries_d;
   logic             fail_q, fail_d;
   logic             accept, take_ack, tmo;
   logic             vld_p1;
   logic [WIDTH-1:0] data_p1;

   assign cyc_o    = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
   assign stb_o    = (state_q == ST_ISSUE);
   assign we_o     = 1'b0;
   assign adr_o    = base_q + ADDR'(sent_q);
   assign busy_o   = (state_q != ST_IDLE);
   assign done_o   = (state_q == ST_END);
   assign fail_o   = fail_q;
   assign valid_o  = vld_p1;
   assign data_o   = data_p1;
   assign len_w    = {1'b0, len_q};
   assign accept   = stb_o && !wat_i;
   // An ack that coincides with rty/err is dropped, not counted.
   assign take_ack = cyc_o && ack_i && !rty_i && !err_i;

`ifdef WB_FETCH_TIMEOUT_EN
   wb_fetch_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .cyc    (cyc_o),
      .kick   (ack_i || accept),
      .expire (tmo)
   );
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      cause = AB_NONE;
      if (cyc_o) begin
         if (err_i)
            cause = AB_ERR;
         else if (tmo)
            cause = AB_TIMEOUT;
         else if (rty_i && !retry_ok(16'(tries_q), RETRY))
            cause = AB_RETRY;
      end
   end

   always_comb begin
      state_d = state_q;
      sent_d  = sent_q;
      rcvd_d  = rcvd_q;
      tries_d = tries_q;
      fail_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fetch_i) begin
               sent_d  = '0;
               rcvd_d  = '0;
               tries_d = '0;
               state_d = (len_i == '0) ? ST_END : ST_ISSUE;
            end
         end
         ST_ISSUE, ST_DRAIN: begin
            if (cause != AB_NONE) begin
               state_d = ST_IDLE;
               fail_d  = 1'b1;
            end else if (rty_i) begin
               // Rewind to the first undelivered word and re-issue from there.
               tries_d = tries_q + CW'(1);
               sent_d  = rcvd_q;
               state_d = ST_ISSUE;
            end else begin
               if (accept)
                  sent_d = sent_q + CW'(1);
               if (take_ack)
                  rcvd_d = rcvd_q + CW'(1);
               if (rcvd_d == len_w)
                  state_d = ST_END;
               else if (sent_d == len_w)
                  state_d = ST_DRAIN;
            end
         end
         ST_END:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         sent_q  <= '0;
         rcvd_q  <= '0;
         tries_q <= '0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sent_q  <= sent_d;
         rcvd_q  <= rcvd_d;
         tries_q <= tries_d;
         fail_q  <= fail_d;
      end
   end

   // Request latch and one-cycle read-data stage
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         base_q  <= '0;
         len_q   <= '0;
         vld_p1  <= 1'b0;
         data_p1 <= '0;
      end else begin
         if (state_q == ST_IDLE && fetch_i) begin
            base_q <= base_i;
            len_q  <= len_i;
         end
         vld_p1 <= take_ack;
         if (take_ack)
            data_p1 <= dat_i;
      end
   end

endmodule

// File: tb/tb_wb_fetch_burst.sv
// Randomised self-checking bench for wb_fetch_burst with a queue-based slave
// model and an expected word stream derived from base and length.
`timescale 1ns/1ps
module tb_wb_fetch_burst;

   localparam int ADDR  = 12;
   localparam int WIDTH = 32;
   localparam int LBITS = 8;
   localparam int RETRY = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             fetch_i;
   logic [ADDR-1:0]  base_i;
   logic [LBITS-1:0] len_i;
   logic             busy_o, done_o, fail_o, valid_o;
   logic [WIDTH-1:0] data_o;
   logic             cyc_o, stb_o, we_o;
   logic [ADDR-1:0]  adr_o;
   logic             ack_i, wat_i, rty_i, err_i;
   logic [WIDTH-1:0] dat_i;

   always #5 clk = ~clk;

   wb_fetch_burst dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .fetch_i (fetch_i),
      .base_i  (base_i),
      .len_i   (len_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .fail_o  (fail_o),
      .valid_o (valid_o),
      .data_o  (data_o),
      .cyc_o   (cyc_o),
      .stb_o   (stb_o),
      .we_o    (we_o),
      .adr_o   (adr_o),
      .ack_i   (ack_i),
      .wat_i   (wat_i),
      .rty_i   (rty_i),
      .err_i   (err_i),
      .dat_i   (dat_i)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] mem(input logic [ADDR-1:0] a);
      return {a, 8'h5A, ~a};
   endfunction

   logic [ADDR-1:0] q[$];
   logic [ADDR-1:0] cur_base, stall_adr;
   int p_ack, p_wat, rty_after, rty_left, err_after, stall_req, stall_left, poke_cyc;
   int reqs, acks, widx, n_valid, n_done, n_fail;
   int cyc_n = 0;
   int ack_cyc, abort_cyc, first_cyc, fail_cyc;
   bit cyc_seen;

   task automatic set_slave(input int a, input int w);
      p_ack = a; p_wat = w;
      rty_after = -1; rty_left = 0; err_after = -1;
      stall_req = -1; stall_left = 0; poke_cyc = -1;
   endtask

   // One clock: observe outputs at the falling edge, then drive the slave.
   task automatic cycle();
      @(negedge clk);
      cyc_n++;
      fetch_i = 1'b0;
      if (cyc_n == poke_cyc) begin
         fetch_i = 1'b1; base_i = 12'h555; len_i = 8'd1;
      end
      if (valid_o) begin
         chk("data", data_o, mem(cur_base + ADDR'(widx)));
         widx++; n_valid++;
      end
      if (cyc_o && !cyc_seen) begin
         cyc_seen = 1'b1; first_cyc = cyc_n;
      end
      if (done_o) begin
         n_done++;
         chk("cyc_at_done", cyc_o, 0);
         if (cyc_seen) chk("done_gap", cyc_n - ack_cyc, 1);
      end
      if (fail_o) begin
         n_fail++; fail_cyc = cyc_n;
         chk("cyc_at_fail", cyc_o, 0);
         chk("busy_at_fail", busy_o, 0);
         if (abort_cyc >= 0) chk("fail_gap", cyc_n - abort_cyc, 1);
      end
      ack_i = 1'b0; rty_i = 1'b0; err_i = 1'b0; wat_i = 1'b0; dat_i = '0;
      if (cyc_o && q.size() > 0 && $urandom_range(99) < p_ack) begin
         if (acks == err_after) begin
            err_i = 1'b1; ack_i = 1'b1; dat_i = mem(q[0]); abort_cyc = cyc_n;
         end else if (rty_left > 0 && acks == rty_after) begin
            rty_i = 1'b1; rty_left--; q.delete(); abort_cyc = cyc_n;
         end else begin
            ack_i = 1'b1; dat_i = mem(q.pop_front()); acks++; ack_cyc = cyc_n;
         end
      end
      if (stb_o && !rty_i && !err_i) begin
         if (stall_left > 0 && reqs == stall_req) begin
            wat_i = 1'b1; stall_left--;
            chk("stall_adr", adr_o, stall_adr);
         end else begin
            wat_i = ($urandom_range(99) < p_wat);
         end
         if (!wat_i) begin
            q.push_back(adr_o); reqs++;
         end
      end
   endtask

   task automatic start_fetch(input logic [ADDR-1:0] base, input logic [LBITS-1:0] len);
      q.delete();
      acks = 0; reqs = 0; widx = 0; n_valid = 0; n_done = 0; n_fail = 0;
      cyc_seen = 1'b0; abort_cyc = -1; ack_cyc = -100; first_cyc = 0; fail_cyc = 0;
      cur_base = base;
      fetch_i = 1'b1; base_i = base; len_i = len;
   endtask

   task automatic run_fetch(input logic [ADDR-1:0] base, input logic [LBITS-1:0] len,
                            input int exp_words, input bit exp_fail);
      int budget;
      start_fetch(base, len);
      budget = 0;
      while (n_done == 0 && n_fail == 0 && budget < 600) begin
         cycle(); budget++;
      end
      chk("fetch_ends", budget < 600, 1);
      repeat (4) cycle();
      chk("words", n_valid, exp_words);
      chk("done_cnt", n_done, exp_fail ? 0 : 1);
      chk("fail_cnt", n_fail, exp_fail ? 1 : 0);
      chk("busy_idle", busy_o, 0);
      chk("cyc_used", cyc_seen, len != 0);
   endtask

   initial begin
      logic [ADDR-1:0]  rb;
      logic [LBITS-1:0] rl;
      rst = 1'b1; fetch_i = 1'b0; base_i = '0; len_i = '0;
      ack_i = 1'b0; wat_i = 1'b0; rty_i = 1'b0; err_i = 1'b0; dat_i = '0;
      set_slave(100, 0);
      repeat (3) @(negedge clk);
      chk("rst_cyc", cyc_o, 0);
      chk("rst_stb", stb_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_fail", fail_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_adr", adr_o, 0);
      chk("rst_we", we_o, 0);
      rst = 1'b0;
      cycle();

      // zero-wait slave, plus a fetch_i poke mid-burst that must be ignored
      set_slave(100, 0);
      poke_cyc = cyc_n + 3;
      run_fetch(12'h010, 8'd4, 4, 1'b0);

      set_slave(100, 0);
      stall_req = 1; stall_left = 2; stall_adr = 12'h011;
      run_fetch(12'h010, 8'd4, 4, 1'b0);
      chk("stall_taken", stall_left, 0);

      set_slave(100, 0);
      run_fetch(12'hFFE, 8'd4, 4, 1'b0);

      set_slave(100, 0);
      rty_after = 2; rty_left = 1;
      run_fetch(12'h040, 8'd4, 4, 1'b0);
      chk("rty_taken", rty_left, 0);

      set_slave(100, 0);
      rty_after = 2; rty_left = RETRY + 1;
      run_fetch(12'h080, 8'd4, 2, 1'b1);
      chk("rty_all_taken", rty_left, 0);

      set_slave(100, 0);
      err_after = 2;
      run_fetch(12'h0C0, 8'd4, 2, 1'b1);

      set_slave(100, 0);
      run_fetch(12'h100, 8'd0, 0, 1'b0);

      // asynchronous reset in the middle of a burst
      set_slave(60, 0);
      start_fetch(12'h200, 8'd10);
      repeat (5) cycle();
      chk("mid_cyc", cyc_o, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_cyc", cyc_o, 0);
      chk("rst_mid_stb", stb_o, 0);
      chk("rst_mid_busy", busy_o, 0);
      n_done = 0; n_fail = 0;
      repeat (3) cycle();
      chk("rst_mid_pulses", n_done + n_fail, 0);
      rst = 1'b0;
      set_slave(100, 0);
      run_fetch(12'h123, 8'd6, 6, 1'b0);

      for (int i = 0; i < 25; i++) begin
         rb = ADDR'($urandom);
         rl = LBITS'($urandom_range(1, 24));
         set_slave($urandom_range(30, 100), $urandom_range(0, 50));
         if ($urandom_range(1) == 1) begin
            rty_left = $urandom_range(1, RETRY);
            rty_after = $urandom_range(0, int'(rl) - 1);
         end
         run_fetch(rb, rl, int'(rl), 1'b0);
      end

`ifdef WB_FETCH_TIMEOUT_EN
      set_slave(0, 100);
      run_fetch(12'h300, 8'd4, 0, 1'b1);
      chk("tmo_gap", fail_cyc - first_cyc, 256);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
